// File: rtl/gpr_multiport_pkg.sv
// Shared types and parameter bounds for the multi-ported general-purpose register file.
package gpr_multiport_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gpr_state_e;

  localparam int NREG_MIN = 16;
  localparam int NREG_MAX = 32;
  localparam int NRD_MIN  = 1;
  localparam int NRD_MAX  = 4;
  localparam int NWR_MIN  = 1;
  localparam int NWR_MAX  = 2;

  function automatic bit nreg_legal(input int n);
    return (n == NREG_MIN) || (n == NREG_MAX);
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, wiped by flush.
module gpr_scoreboard
  import gpr_multiport_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     run_i,
  input  logic                     set_i,
  input  logic [$clog2(NREG)-1:0]  set_idx_i,
  input  logic [NREG-1:0]          clr_i,
  input  logic                     flush_i,
  output logic [NREG-1:0]          busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // Priority low to high: write-back clear, issue set, flush.
  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (set_i && run_i && (set_idx_i != '0)) begin
      busy_d[set_idx_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/gpr_multiport.sv
// Multi-ported register file with same-cycle forwarding, busy scoreboard and
// a post-reset sweep that zeroes the (non-reset) storage array.
module gpr_multiport
  import gpr_multiport_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_idx,
  output logic [NRD*XLEN-1:0]           rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic [NWR-1:0]                wr_valid,
  input  logic [NWR-1:0]                wr_trap,
  input  logic [NWR*$clog2(NREG)-1:0]   wr_idx,
  input  logic [NWR*XLEN-1:0]           wr_data,
  input  logic                          iss_valid,
  input  logic [$clog2(NREG)-1:0]       iss_idx,
  input  logic                          flush,
  output logic                          init_done
);

  localparam int AW = $clog2(NREG);

  if (!nreg_legal(NREG) || (NRD < NRD_MIN) || (NRD > NRD_MAX) ||
      (NWR < NWR_MIN) || (NWR > NWR_MAX)) begin : g_bad_param
    $error("gpr_multiport: illegal NREG/NRD/NWR");
  end

  gpr_state_e        state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              init_wr;
  logic [XLEN-1:0]   regs_q [NREG];
  logic [NWR-1:0]    commit;
  logic [NREG-1:0]   clr;
  logic [NREG-1:0]   busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // INIT zeroes index cnt_q each cycle; the last index hands over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign init_done = (state_q == ST_RUN);

  always_comb begin
    commit = '0;
    clr    = '0;
    for (int w = 0; w < NWR; w++) begin
      commit[w] = wr_valid[w] & ~wr_trap[w] & (wr_idx[w*AW +: AW] != '0) & init_done;
      if (commit[w]) begin
        clr[wr_idx[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // Later ports are assigned last, so the highest-numbered committing port wins.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      regs_q[cnt_q] <= '0;
    end
    for (int w = 0; w < NWR; w++) begin
      if (commit[w]) begin
        regs_q[wr_idx[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = regs_q[rd_idx[p*AW +: AW]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (commit[w] && (wr_idx[w*AW +: AW] == rd_idx[p*AW +: AW])) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          end
        end
      end
      // Index 0 is never stored; storage is undefined until the sweep ends.
      if (!init_done || (rd_idx[p*AW +: AW] == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
      end
      rd_busy[p] = init_done & busy[rd_idx[p*AW +: AW]];
    end
  end

  gpr_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .run_i     (init_done),
    .set_i     (iss_valid),
    .set_idx_i (iss_idx),
    .clr_i     (clr),
    .flush_i   (flush),
    .busy_o    (busy)
  );

endmodule

// File: tb/tb_gpr_multiport.sv
// Bench for gpr_multiport: one forwarding and one non-forwarding instance driven in lockstep.
module tb_gpr_multiport;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    rd_idx;
  logic [127:0]  rd_data_b, rd_data_n;
  logic [1:0]    rd_busy_b, rd_busy_n;
  logic [1:0]    wr_valid, wr_trap;
  logic [9:0]    wr_idx;
  logic [127:0]  wr_data;
  logic          iss_valid;
  logic [4:0]    iss_idx;
  logic          flush;
  logic          init_done_b, init_done_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_regs [32];
  bit          m_busy [32];
  bit          m_run;

  typedef struct {
    logic [1:0]  wv, wt;
    logic [4:0]  wi0, wi1;
    logic [63:0] wd0, wd1;
    logic        iv;
    logic [4:0]  ii;
    logic        fl;
    logic [4:0]  ri0, ri1;
    logic [63:0] e_b0, e_n0, e_b1;
    logic [1:0]  e_busy;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  gpr_multiport #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_valid(wr_valid), .wr_trap(wr_trap), .wr_idx(wr_idx), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .flush(flush), .init_done(init_done_b)
  );

  gpr_multiport #(.XLEN(64), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_valid(wr_valid), .wr_trap(wr_trap), .wr_idx(wr_idx), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .flush(flush), .init_done(init_done_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] wv, input logic [1:0] wt,
                              input logic [4:0] wi0, input logic [4:0] wi1,
                              input logic [63:0] wd0, input logic [63:0] wd1,
                              input logic iv, input logic [4:0] ii, input logic fl,
                              input logic [4:0] ri0, input logic [4:0] ri1,
                              input logic [63:0] e_b0, input logic [63:0] e_n0,
                              input logic [63:0] e_b1, input logic [1:0] e_busy);
    vec_t v;
    v.wv = wv; v.wt = wt; v.wi0 = wi0; v.wi1 = wi1; v.wd0 = wd0; v.wd1 = wd1;
    v.iv = iv; v.ii = ii; v.fl = fl; v.ri0 = ri0; v.ri1 = ri1;
    v.e_b0 = e_b0; v.e_n0 = e_n0; v.e_b1 = e_b1; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_valid = '0; wr_trap = '0; wr_idx = '0; wr_data = '0;
    iss_valid = 1'b0; iss_idx = '0; flush = 1'b0; rd_idx = '0;
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic bit m_commit(input int w);
    return m_run && wr_valid[w] && !wr_trap[w] && (wr_idx[w*5 +: 5] != 5'd0);
  endfunction

  function automatic logic [63:0] model_rd(input logic [4:0] idx, input bit byp);
    logic [63:0] v;
    if (!m_run || idx == 5'd0) return 64'd0;
    v = m_regs[idx];
    if (byp) begin
      for (int w = 0; w < 2; w++) begin
        if (m_commit(w) && wr_idx[w*5 +: 5] == idx) v = wr_data[w*64 +: 64];
      end
    end
    return v;
  endfunction

  task automatic model_edge();
    if (!m_run) return;
    for (int w = 0; w < 2; w++) begin
      if (m_commit(w)) begin
        m_regs[wr_idx[w*5 +: 5]] = wr_data[w*64 +: 64];
        m_busy[wr_idx[w*5 +: 5]] = 1'b0;
      end
    end
    if (iss_valid && iss_idx != 5'd0) m_busy[iss_idx] = 1'b1;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end
  endtask

  task automatic model_cycle(input string tag);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk({tag, "_rd_byp"}, rd_data_b[p*64 +: 64], model_rd(rd_idx[p*5 +: 5], 1'b1));
      chk({tag, "_rd_nob"}, rd_data_n[p*64 +: 64], model_rd(rd_idx[p*5 +: 5], 1'b0));
      chk({tag, "_busy_b"}, rd_busy_b[p], m_run & m_busy[rd_idx[p*5 +: 5]]);
      chk({tag, "_busy_n"}, rd_busy_n[p], m_run & m_busy[rd_idx[p*5 +: 5]]);
    end
    chk({tag, "_init_done"}, init_done_b, m_run);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Counts edges from reset release to init_done, driving writes/issues that must be ignored.
  task automatic wait_init(input string tag);
    int cyc;
    cyc = 0;
    while (init_done_b !== 1'b1 && cyc < 100) begin
      wr_valid = 2'b11; wr_trap = 2'b00; wr_idx = {5'd4, 5'd4};
      wr_data = {64'h77, 64'h77}; iss_valid = 1'b1; iss_idx = 5'd4;
      rd_idx = {5'd4, 5'd4};
      #1;
      chk("init_rd_zero", rd_data_b[63:0], 64'd0);
      chk("init_busy_zero", {62'd0, rd_busy_b}, 64'd0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, cyc, 64'd31);
    chk({tag, "_done_nob"}, init_done_n, 1'b1);
    idle_inputs();
    m_run = 1'b1;
  endtask

  initial begin
    idle_inputs();
    model_reset();

    tbl[0]  = mk(2'b01, 2'b00, 5'd5,  5'd0,  64'hDEAD_BEEF, 64'h0,  1'b0, 5'd0,  1'b0, 5'd5,  5'd5,  64'hDEAD_BEEF, 64'h0,         64'hDEAD_BEEF, 2'b00);
    tbl[1]  = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd5,  5'd0,  64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'h0,         2'b00);
    tbl[2]  = mk(2'b11, 2'b00, 5'd7,  5'd7,  64'h11,        64'h22, 1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  64'h22,        64'h0,         64'h22,        2'b00);
    tbl[3]  = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd7,  5'd5,  64'h22,        64'h22,        64'hDEAD_BEEF, 2'b00);
    tbl[4]  = mk(2'b01, 2'b00, 5'd0,  5'd0,  64'hFFFF,      64'h0,  1'b1, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,         64'h0,         64'h0,         2'b00);
    tbl[5]  = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  64'h0,         64'h0,         64'h0,         2'b00);
    tbl[6]  = mk(2'b01, 2'b00, 5'd3,  5'd0,  64'h33,        64'h0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h33,        64'h0,         64'h33,        2'b00);
    tbl[7]  = mk(2'b01, 2'b01, 5'd3,  5'd0,  64'h99,        64'h0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h33,        64'h33,        64'h33,        2'b00);
    tbl[8]  = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd3,  5'd3,  64'h33,        64'h33,        64'h33,        2'b00);
    tbl[9]  = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  64'h0,         64'h0,         64'h0,         2'b00);
    tbl[10] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  64'h0,         64'h0,         64'h0,         2'b11);
    tbl[11] = mk(2'b10, 2'b00, 5'd0,  5'd9,  64'h0,         64'hAB, 1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  64'hAB,        64'h0,         64'hAB,        2'b11);
    tbl[12] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  64'hAB,        64'hAB,        64'hAB,        2'b11);
    tbl[13] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b1, 5'd9,  5'd9,  64'hAB,        64'hAB,        64'hAB,        2'b11);
    tbl[14] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  64'hAB,        64'hAB,        64'hAB,        2'b00);
    tbl[15] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b1, 5'd12, 1'b1, 5'd12, 5'd9,  64'h0,         64'h0,         64'hAB,        2'b00);
    tbl[16] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd12, 5'd9,  64'h0,         64'h0,         64'hAB,        2'b00);
    tbl[17] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b1, 5'd12, 1'b0, 5'd12, 5'd12, 64'h0,         64'h0,         64'h0,         2'b00);
    tbl[18] = mk(2'b01, 2'b00, 5'd12, 5'd0,  64'h1234,      64'h0,  1'b0, 5'd0,  1'b0, 5'd12, 5'd12, 64'h1234,      64'h0,         64'h1234,      2'b11);
    tbl[19] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd12, 5'd12, 64'h1234,      64'h1234,      64'h1234,      2'b00);
    tbl[20] = mk(2'b11, 2'b10, 5'd20, 5'd21, 64'hAAAA,      64'hBBBB, 1'b0, 5'd0, 1'b0, 5'd20, 5'd21, 64'hAAAA,      64'h0,         64'h0,         2'b00);
    tbl[21] = mk(2'b00, 2'b00, 5'd0,  5'd0,  64'h0,         64'h0,  1'b0, 5'd0,  1'b0, 5'd20, 5'd21, 64'hAAAA,      64'hAAAA,      64'h0,         2'b00);

    // Reset, abort the sweep part-way, then let a full sweep complete.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midinit_reset_done", init_done_b, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init");

    for (int i = 0; i < 32; i++) begin
      rd_idx = {i[4:0], i[4:0]};
      model_cycle("scan_zero");
    end

    // Directed vectors.
    for (int r = 0; r < 22; r++) begin
      wr_valid = tbl[r].wv; wr_trap = tbl[r].wt;
      wr_idx = {tbl[r].wi1, tbl[r].wi0}; wr_data = {tbl[r].wd1, tbl[r].wd0};
      iss_valid = tbl[r].iv; iss_idx = tbl[r].ii; flush = tbl[r].fl;
      rd_idx = {tbl[r].ri1, tbl[r].ri0};
      #1;
      chk($sformatf("tbl%0d_rd0_byp", r), rd_data_b[63:0], tbl[r].e_b0);
      chk($sformatf("tbl%0d_rd0_nob", r), rd_data_n[63:0], tbl[r].e_n0);
      chk($sformatf("tbl%0d_rd1_byp", r), rd_data_b[127:64], tbl[r].e_b1);
      chk($sformatf("tbl%0d_busy_b", r), rd_busy_b, tbl[r].e_busy);
      chk($sformatf("tbl%0d_busy_n", r), rd_busy_n, tbl[r].e_busy);
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
    idle_inputs();

    // Random traffic on a narrow index range so collisions are frequent.
    for (int c = 0; c < 400; c++) begin
      wr_valid  = 2'($urandom_range(0, 3));
      wr_trap   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      wr_idx    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wr_data   = {$urandom, $urandom, $urandom, $urandom};
      iss_valid = 1'($urandom_range(0, 1));
      iss_idx   = 5'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 15) == 0);
      rd_idx    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      model_cycle("rnd");
    end
    idle_inputs();

    // Reset during RUN discards stored contents.
    wr_valid = 2'b01; wr_idx = {5'd0, 5'd4}; wr_data = {64'h0, 64'h55};
    model_cycle("x4_write");
    idle_inputs();
    rd_idx = {5'd4, 5'd4};
    #1 chk("x4_before_reset", rd_data_n[63:0], 64'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("run_reset_done_drop", init_done_b, 1'b0);
    chk("run_reset_rd_zero", rd_data_b[63:0], 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    rd_idx = {5'd4, 5'd4};
    #1;
    chk("x4_after_sweep", rd_data_b[63:0], 64'd0);
    chk("x4_busy_after_sweep", rd_busy_b[0], 1'b0);
    @(negedge clk);
    rd_idx = {5'd31, 5'd4};
    model_cycle("post_reinit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_multiport.md
GPR_MULTIPORT -- requirements
Module: gpr_multiport

Interface
REQ-001 Parameter XLEN, default 64, register width in bits.
REQ-002 Parameter NREG, default 32, register count (legal values 16 or 32; index width AW = log2(NREG)).
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter NWR, default 1, number of write ports (1..2).
REQ-005 Parameter BYPASS, default 1, enables write-to-read forwarding in the same cycle.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 rd_idx  input  NRD*AW  read indices; port p occupies bits [p*AW +: AW].
REQ-009 rd_data  output  NRD*XLEN  read data per port.
REQ-010 rd_busy  output  NRD  scoreboard busy bit of each read index.
REQ-011 wr_valid  input  NWR  write request per port.
REQ-012 wr_trap  input  NWR  write suppression per port (trapped instruction).
REQ-013 wr_idx  input  NWR*AW  destination index per write port.
REQ-014 wr_data  input  NWR*XLEN  write data per port.
REQ-015 iss_valid  input  1  issue of an instruction with a destination; marks wr target busy.
REQ-016 iss_idx  input  AW  destination index of the issuing instruction.
REQ-017 flush  input  1  clears all busy bits (pipeline flush).
REQ-018 init_done  output  1  high once post-reset register clearing has finished.

Function
REQ-019 A write on port w commits when wr_valid[w] & !wr_trap[w] & wr_idx[w]!=0 & init_done.
REQ-020 Index 0 shall never be written, never be busy, and always read as zero.
REQ-021 When two ports commit to the same index in one cycle, the higher-numbered port's data shall be stored.
REQ-022 Reads are combinational; with BYPASS=0, rd_data reflects state before the current edge.
REQ-023 With BYPASS=1, a read matching a committing write index shall return that write's data in the same cycle, using the priority of REQ-021.
REQ-024 Busy bit of index i is set on the edge where iss_valid & iss_idx==i & i!=0 & init_done.
REQ-025 Busy bit of index i is cleared on the edge where a write to index i commits.
REQ-026 Simultaneous set and clear of the same index: set wins (the newer producer remains outstanding).
REQ-027 flush clears all busy bits on the edge and overrides any same-cycle set.
REQ-028 rd_busy[p] shall reflect the registered busy bit and is not bypassed by same-cycle clears.
REQ-029 Init state machine, states INIT and RUN: INIT writes zero to one register per cycle, counting 1..NREG-1, then moves to RUN.
REQ-030 In INIT, rd_data shall be zero, rd_busy zero, init_done low, and all writes and issues ignored.
REQ-031 INIT shall last exactly NREG-1 cycles after rst_n deasserts; init_done rises on the following edge and stays high until reset.

Reset
REQ-032 Asserting rst_n low shall immediately force state INIT, the sweep counter to 1, all busy bits to 0, and init_done to 0.
REQ-033 The register array itself shall not be asynchronously reset; INIT zeroes it.
REQ-034 Reset asserted mid-INIT or mid-RUN shall restart the full sweep.

Structure
REQ-035 The shared package holds the FSM state enum (INIT, RUN) and the legal NREG/NRD/NWR bounds.
REQ-036 One sub-module, gpr_scoreboard, implements the busy-bit logic of REQ-024..REQ-028.

Verification
REQ-037 Release reset, then count cycles: init_done rises after 31 cycles (NREG=32), and every index reads 0.
REQ-038 Write 0xDEAD_BEEF to x5 with BYPASS=1 and read x5 in the same cycle: rd_data=0xDEAD_BEEF; with BYPASS=0 the old value is returned until the next cycle.
REQ-039 Ports 0 and 1 both write x7, with values 0x11 and 0x22: x7 holds 0x22 afterwards.
REQ-040 Write x0=0xFFFF plus issue x0: x0 still reads 0 and its busy bit stays 0; a write with wr_trap=1 to x3 leaves x3 unchanged.
REQ-041 Issue x9, then issue x9 again in the same cycle that x9 is written back: busy stays 1; a following flush leaves busy at 0.
REQ-042 Pulse rst_n low during RUN after writing x4=0x55: init_done drops at once and x4 reads 0 after the sweep.
